// File: rtl/seq_pattern_serializer_pkg.sv
//==============================================================================
// Module  : seq_pattern_serializer_pkg
// Purpose : Shared FSM state encodings and default sizing constants for the
//           serial pattern serializer and its companion sequence detector.
// Ports   : none (package)
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

package seq_pattern_serializer_pkg;

  // Serializer FSM: idle (ready for a load) or shifting a pattern out.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_t;

  localparam int c_default_width = 8;
  localparam int c_default_div   = 4;

endpackage : seq_pattern_serializer_pkg

`default_nettype wire

// File: rtl/bit_tick_divider.sv
//==============================================================================
// Module  : bit_tick_divider
// Purpose : Counts sys_clk cycles 0..DIV-1 while enabled and flags the last
//           cycle of each window. Used to pace one serial bit per window.
// Ports   : sys_clk  in  clock
//           sys_rst  in  synchronous active-high reset
//           clr      in  force count to 0 (dominates en)
//           en       in  count enable
//           tick     out high while en and count == DIV-1
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

module bit_tick_divider #(
  parameter int DIV = 4
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  // Keep at least one counter bit so DIV=1 still elaborates cleanly.
  localparam int c_cnt_w = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DIV - 1);

  logic [c_cnt_w-1:0] r_count;

  always_ff @(posedge sys_clk) begin
    if (sys_rst || clr) begin
      r_count <= '0;
    end else if (en) begin
      if (r_count == c_last) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + c_cnt_w'(1);
      end
    end
  end

  assign tick = en && (r_count == c_last);

endmodule : bit_tick_divider

`default_nettype wire

// File: rtl/seq_pattern_serializer.sv
//==============================================================================
// Module  : seq_pattern_serializer
// Purpose : Accepts a WIDTH-bit pattern and a pass count over valid/ready and
//           shifts it out on seq_out, one bit per DIV-cycle window, repeating
//           for the requested number of passes (0 = until abort).
// Ports   : sys_clk       in   clock, all logic on posedge
//           sys_rst       in   synchronous active-high reset
//           load_valid    in   pattern/passes offered
//           load_ready    out  idle, load can be accepted
//           load_pattern  in   [WIDTH-1:0] bits to serialize
//           load_passes   in   [7:0] pass count, 0 = continuous
//           abort         in   stop an in-progress transfer
//           seq_out       out  current serial bit
//           bit_strobe    out  last cycle of each bit window
//           busy          out  shifting
//           done          out  1-cycle pulse after final bit of final pass
// Config  : define SEQ_SER_LSB_FIRST_EN to shift LSB first (default MSB first)
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

module seq_pattern_serializer
  import seq_pattern_serializer_pkg::*;
#(
  parameter int WIDTH = c_default_width,
  parameter int DIV   = c_default_div
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_pattern,
  input  logic [7:0]       load_passes,
  input  logic             abort,
  output logic             seq_out,
  output logic             bit_strobe,
  output logic             busy,
  output logic             done
);

  localparam int c_idx_w = $clog2(WIDTH);

`ifdef SEQ_SER_LSB_FIRST_EN
  localparam logic [c_idx_w-1:0] c_first_idx = '0;
  localparam logic [c_idx_w-1:0] c_last_idx  = c_idx_w'(WIDTH - 1);
`else
  localparam logic [c_idx_w-1:0] c_first_idx = c_idx_w'(WIDTH - 1);
  localparam logic [c_idx_w-1:0] c_last_idx  = '0;
`endif

  ser_state_t         r_state;
  ser_state_t         w_state_next;
  logic [WIDTH-1:0]   r_pattern;
  logic [c_idx_w-1:0] r_index;
  logic [c_idx_w-1:0] w_index_step;
  logic [7:0]         r_passes;
  logic               r_done;
  logic               w_accept;
  logic               w_final;
  logic               w_tick;
  logic               w_shifting;

  assign w_shifting = (r_state == ST_SHIFT);

  // Held clear whenever idle, so every accepted transfer starts a fresh window.
  bit_tick_divider #(
    .DIV (DIV)
  ) u_div (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .clr     (!w_shifting),
    .en      (w_shifting),
    .tick    (w_tick)
  );

`ifdef SEQ_SER_LSB_FIRST_EN
  assign w_index_step = r_index + c_idx_w'(1);
`else
  assign w_index_step = r_index - c_idx_w'(1);
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Abort is checked first so it wins over a coincident final strobe.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_final      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (load_valid) begin
          w_accept     = 1'b1;
          w_state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          w_state_next = ST_IDLE;
        end else if (w_tick && (r_index == c_last_idx) && (r_passes == 8'd1)) begin
          w_final      = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_pattern <= '0;
      r_passes  <= '0;
      r_index   <= c_first_idx;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_final;
      if (w_accept) begin
        r_pattern <= load_pattern;
        r_passes  <= load_passes;
        r_index   <= c_first_idx;
      end else if (w_shifting && w_tick && !abort) begin
        if (r_index == c_last_idx) begin
          r_index <= c_first_idx;
          // A zero count means continuous mode and is never decremented.
          if (r_passes != 8'd0) begin
            r_passes <= r_passes - 8'd1;
          end
        end else begin
          r_index <= w_index_step;
        end
      end
    end
  end

  assign seq_out    = w_shifting & r_pattern[r_index];
  assign bit_strobe = w_tick;
  assign busy       = w_shifting;
  assign load_ready = !w_shifting;
  assign done       = r_done;

endmodule : seq_pattern_serializer

`default_nettype wire

// File: tb/tb_seq_pattern_serializer.sv
//==============================================================================
// Module  : tb_seq_pattern_serializer
// Purpose : Directed self-checking bench for seq_pattern_serializer
//           (WIDTH=8, DIV=4). Honors SEQ_SER_LSB_FIRST_EN for bit order.
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_seq_pattern_serializer;

  localparam int c_width = 8;
  localparam int c_div   = 4;

  localparam int MODE_DONE  = 0;
  localparam int MODE_ABORT = 1;
  localparam int MODE_RST   = 2;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] load_pattern;
  logic [7:0] load_passes;
  logic       abort;
  logic       seq_out;
  logic       bit_strobe;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_bad = 0;

  // Hand-derived serial order of 8'b10111001.
`ifdef SEQ_SER_LSB_FIRST_EN
  logic c_exp_seq [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
`else
  logic c_exp_seq [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
`endif

  seq_pattern_serializer #(
    .WIDTH (c_width),
    .DIV   (c_div)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_pattern (load_pattern),
    .load_passes  (load_passes),
    .abort        (abort),
    .seq_out      (seq_out),
    .bit_strobe   (bit_strobe),
    .busy         (busy),
    .done         (done)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic exp_done);
    chk({tag, ".seq_out"},    seq_out,    1'b0);
    chk({tag, ".load_ready"}, load_ready, 1'b1);
    chk({tag, ".busy"},       busy,       1'b0);
    chk({tag, ".bit_strobe"}, bit_strobe, 1'b0);
    chk({tag, ".done"},       done,       exp_done);
  endtask

  // Loads 8'b10111001 in the current cycle, checks n cycles of shifting, then
  // finishes according to mode. Ends on a sample point with no extra step, so
  // a following call loads in the done cycle (back-to-back accept).
  task automatic run_xfer(input string tag, input logic [7:0] passes,
                          input int n, input int mode, input int inject_k);
    load_pattern = 8'b1011_1001;
    load_passes  = passes;
    load_valid   = 1'b1;
    step();
    load_valid   = 1'b0;
    load_pattern = 8'h00;
    load_passes  = 8'h00;
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s.k%0d.seq_out", tag, k), seq_out, c_exp_seq[(k / c_div) % c_width]);
      chk($sformatf("%s.k%0d.strobe", tag, k), bit_strobe, ((k % c_div) == c_div - 1));
      chk($sformatf("%s.k%0d.busy", tag, k), busy, 1'b1);
      chk($sformatf("%s.k%0d.ready", tag, k), load_ready, 1'b0);
      chk($sformatf("%s.k%0d.done", tag, k), done, 1'b0);
      if (k == inject_k) begin
        load_pattern = 8'hFF;
        load_passes  = 8'd5;
        load_valid   = 1'b1;
      end
      if (k == n - 1 && mode == MODE_ABORT) abort = 1'b1;
      if (k == n - 1 && mode == MODE_RST) sys_rst = 1'b1;
      step();
      load_valid = 1'b0;
      abort      = 1'b0;
      sys_rst    = 1'b0;
    end
    if (mode == MODE_DONE) begin
      chk_idle({tag, ".end"}, 1'b1);
    end else begin
      chk_idle({tag, ".end"}, 1'b0);
      step();
      chk_idle({tag, ".end+1"}, 1'b0);
    end
  endtask

  initial begin
    sys_rst      = 1'b1;
    load_valid   = 1'b0;
    load_pattern = 8'h00;
    load_passes  = 8'h00;
    abort        = 1'b0;
    step();
    step();
    sys_rst = 1'b0;
    chk_idle("reset", 1'b0);

    // Abort while idle has no effect.
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_idle("idle_abort", 1'b0);

    // Single pass: done 32 cycles after accept.
    run_xfer("one_pass", 8'd1, 32, MODE_DONE, -1);
    // Three passes, loaded in the done cycle of the previous transfer.
    run_xfer("three_pass", 8'd3, 96, MODE_DONE, -1);
    step();
    chk_idle("done_fall", 1'b0);

    // Continuous mode aborted in the cycle of the 20th strobe.
    run_xfer("cont_abort", 8'd0, 80, MODE_ABORT, -1);

    // Load offered mid-pass is ignored; original pattern completes.
    run_xfer("busy_load", 8'd1, 32, MODE_DONE, 12);
    step();

    // Reset asserted during the 5th bit.
    run_xfer("mid_reset", 8'd1, 17, MODE_RST, -1);

    // Normal operation after reset.
    run_xfer("post_reset", 8'd2, 64, MODE_DONE, -1);
    step();

    // Abort coincident with the final strobe wins: no done.
    run_xfer("abort_final", 8'd1, 32, MODE_ABORT, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_seq_pattern_serializer

`default_nettype wire
